hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's fixed load-use/branch hazard unit. It tracks pending register writes in a per-register latency scoreboard, so producers with latency 1..MAX_LAT (ALU, load, multi-cycle mul/div) stall dependants exactly as long as needed. It generates F/D/E stall, flush and freeze enables, plus D- and E-stage forwarding selects. It sits beside the 5-stage datapath and replaces the fixed-rule hazard logic.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/ctrl_bus_if.sv | 7 +
 rtl/hazard_sb_bank.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the latency-scoreboard hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int MAX_LAT_DEF = 4;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;
    localparam int LAT_MUL     = MAX_LAT_DEF;

    // Width of a counter that can hold 0..max_lat.
    function automatic int lat_w(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock and synchronous reset bundle shared by the pipeline control blocks.
interface ctrl_bus_if;
    logic clk;
    logic reset;

    modport central (input clk, input reset);
endinterface

// File: rtl/hazard_sb_bank.sv
// Per-register pending-write latency counters with issue, decrement and freeze.
module hazard_sb_bank
    import hazard_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int MAX_LAT  = 4,
    localparam int NREG    = 2 ** REG_BITS,
    localparam int LAT_W   = lat_w(MAX_LAT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,
    input  logic                issue,
    input  logic [REG_BITS-1:0] issue_id,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic [REG_BITS-1:0] rs_id,
    input  logic [REG_BITS-1:0] rt_id,
    input  logic [REG_BITS-1:0] rd_id,
    output logic [LAT_W-1:0]    cnt_rs,
    output logic [LAT_W-1:0]    cnt_rt,
    output logic [LAT_W-1:0]    cnt_rd
);

    logic [NREG-1:0][LAT_W-1:0] cnt_q;
    logic [NREG-1:0][LAT_W-1:0] cnt_d;

    // An issue to r overrides its own decrement; entry 0 never holds a count.
    always_comb begin
        cnt_d = cnt_q;
        if (!freeze) begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && (issue_id == REG_BITS'(r))) begin
                    cnt_d[r] = issue_lat;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LAT_W'(1);
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_rs = cnt_q[rs_id];
    assign cnt_rt = cnt_q[rt_id];
    assign cnt_rd = cnt_q[rd_id];

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit: stall/flush/freeze enables, forwarding selects, stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int MAX_LAT  = 4,
    parameter int PERF_W   = 16,
    localparam int LAT_W   = lat_w(MAX_LAT)
) (
    ctrl_bus_if.central         ctrl_bus,
    input  logic [REG_BITS-1:0] rs_D,
    input  logic [REG_BITS-1:0] rt_D,
    input  logic                use_rs_D,
    input  logic                use_rt_D,
    input  logic                branch_D,
    input  logic                wr_D,
    input  logic [REG_BITS-1:0] reg_id_D,
    input  logic [LAT_W-1:0]    lat_D,
    input  logic [REG_BITS-1:0] rs_E,
    input  logic [REG_BITS-1:0] rt_E,
    input  logic [REG_BITS-1:0] reg_id_M,
    input  logic [REG_BITS-1:0] reg_id_W,
    input  logic                reg_write_M,
    input  logic                reg_write_W,
    input  logic                mem_stall,
    output logic                pc_enab,
    output logic                enab_FD,
    output logic                flush_DE,
    output logic                enab_pipe,
    output logic                forwardA_D,
    output logic                forwardB_D,
    output logic [1:0]          forwardA_E,
    output logic [1:0]          forwardB_E,
    output logic [PERF_W-1:0]   stall_cycles
);

    logic [LAT_W-1:0]  cnt_rs;
    logic [LAT_W-1:0]  cnt_rt;
    logic [LAT_W-1:0]  cnt_rd;
    logic              stall_D;
    logic              issue;
    logic              m_fwd_ok;
    logic              w_fwd_ok;
    fwd_sel_e          fwd_a_e;
    fwd_sel_e          fwd_b_e;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    hazard_sb_bank #(
        .REG_BITS (REG_BITS),
        .MAX_LAT  (MAX_LAT)
    ) u_bank (
        .clk       (ctrl_bus.clk),
        .reset     (ctrl_bus.reset),
        .freeze    (mem_stall),
        .issue     (issue),
        .issue_id  (reg_id_D),
        .issue_lat (lat_D),
        .rs_id     (rs_D),
        .rt_id     (rt_D),
        .rd_id     (reg_id_D),
        .cnt_rs    (cnt_rs),
        .cnt_rt    (cnt_rt),
        .cnt_rd    (cnt_rd)
    );

    // Decode compares need the value one cycle earlier than the E-stage ALU does.
    always_comb begin
        stall_D = 1'b0;
        if ((use_rs_D && (cnt_rs >= LAT_W'(2))) || (use_rt_D && (cnt_rt >= LAT_W'(2)))) begin
            stall_D = 1'b1;
        end
        if (branch_D && ((use_rs_D && (cnt_rs != '0)) || (use_rt_D && (cnt_rt != '0)))) begin
            stall_D = 1'b1;
        end
        if (wr_D && (cnt_rd > lat_D)) begin
            stall_D = 1'b1;
        end
        issue = wr_D && (reg_id_D != '0) && !stall_D && !mem_stall;
    end

    always_comb begin
        m_fwd_ok = reg_write_M && (reg_id_M != '0);
        w_fwd_ok = reg_write_W && (reg_id_W != '0);

        fwd_a_e = FWD_RF;
        if (m_fwd_ok && (reg_id_M == rs_E)) begin
            fwd_a_e = FWD_M;
        end else if (w_fwd_ok && (reg_id_W == rs_E)) begin
            fwd_a_e = FWD_W;
        end

        fwd_b_e = FWD_RF;
        if (m_fwd_ok && (reg_id_M == rt_E)) begin
            fwd_b_e = FWD_M;
        end else if (w_fwd_ok && (reg_id_W == rt_E)) begin
            fwd_b_e = FWD_W;
        end

        forwardA_D = m_fwd_ok && (reg_id_M == rs_D);
        forwardB_D = m_fwd_ok && (reg_id_M == rt_D);
        forwardA_E = fwd_a_e;
        forwardB_E = fwd_b_e;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_D || mem_stall) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge ctrl_bus.clk) begin
        if (ctrl_bus.reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A freeze holds every stage in place, so no bubble is injected then.
    assign pc_enab      = !(stall_D || mem_stall);
    assign enab_FD      = !(stall_D || mem_stall);
    assign flush_DE     = stall_D && !mem_stall;
    assign enab_pipe    = !mem_stall;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random and directed stimulus against a ready-time reference model of the hazard unit.
module tb_hazard_scoreboard;

    localparam int REG_BITS = 5;
    localparam int MAX_LAT  = 4;
    localparam int PERF_W   = 16;
    localparam int NREG     = 2 ** REG_BITS;
    localparam int LAT_W    = $clog2(MAX_LAT + 1);
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    ctrl_bus_if ctrl_bus ();

    logic [REG_BITS-1:0] rs_D, rt_D, reg_id_D, rs_E, rt_E, reg_id_M, reg_id_W;
    logic                use_rs_D, use_rt_D, branch_D, wr_D;
    logic [LAT_W-1:0]    lat_D;
    logic                reg_write_M, reg_write_W, mem_stall;
    logic                pc_enab, enab_FD, flush_DE, enab_pipe, forwardA_D, forwardB_D;
    logic [1:0]          forwardA_E, forwardB_E;
    logic [PERF_W-1:0]   stall_cycles;

    hazard_scoreboard #(
        .REG_BITS (REG_BITS),
        .MAX_LAT  (MAX_LAT),
        .PERF_W   (PERF_W)
    ) dut (
        .ctrl_bus     (ctrl_bus),
        .rs_D         (rs_D),
        .rt_D         (rt_D),
        .use_rs_D     (use_rs_D),
        .use_rt_D     (use_rt_D),
        .branch_D     (branch_D),
        .wr_D         (wr_D),
        .reg_id_D     (reg_id_D),
        .lat_D        (lat_D),
        .rs_E         (rs_E),
        .rt_E         (rt_E),
        .reg_id_M     (reg_id_M),
        .reg_id_W     (reg_id_W),
        .reg_write_M  (reg_write_M),
        .reg_write_W  (reg_write_W),
        .mem_stall    (mem_stall),
        .pc_enab      (pc_enab),
        .enab_FD      (enab_FD),
        .flush_DE     (flush_DE),
        .enab_pipe    (enab_pipe),
        .forwardA_D   (forwardA_D),
        .forwardB_D   (forwardB_D),
        .forwardA_E   (forwardA_E),
        .forwardB_E   (forwardB_E),
        .stall_cycles (stall_cycles)
    );

    initial ctrl_bus.clk = 1'b0;
    always #5 ctrl_bus.clk = ~ctrl_bus.clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: time advances only on unfrozen cycles; a register is pending until its ready time.
    longint t_adv;
    longint ready_at [NREG];
    int     perf_m;
    bit     last_flush;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int remaining(input int r);
        if (r == 0 || ready_at[r] <= t_adv) return 0;
        return int'(ready_at[r] - t_adv);
    endfunction

    function automatic int fwd_e(input int src);
        if (reg_write_M && reg_id_M != 0 && int'(reg_id_M) == src) return 2;
        if (reg_write_W && reg_id_W != 0 && int'(reg_id_W) == src) return 1;
        return 0;
    endfunction

    task automatic idle();
        rs_D = '0; rt_D = '0; use_rs_D = 0; use_rt_D = 0; branch_D = 0;
        wr_D = 0; reg_id_D = '0; lat_D = LAT_W'(1);
        rs_E = '0; rt_E = '0; reg_id_M = '0; reg_id_W = '0;
        reg_write_M = 0; reg_write_W = 0; mem_stall = 0; ctrl_bus.reset = 0;
    endtask

    // Inputs are already applied; check settled outputs, advance model, wait one clock.
    task automatic step(input bit do_chk);
        int  rrs, rrt, rrd;
        bit  raw, stall, iss;
        #1;
        rrs = remaining(int'(rs_D));
        rrt = remaining(int'(rt_D));
        rrd = remaining(int'(reg_id_D));
        raw = (use_rs_D && rrs >= 2) || (use_rt_D && rrt >= 2);
        stall = raw || (branch_D && ((use_rs_D && rrs >= 1) || (use_rt_D && rrt >= 1)))
                || (wr_D && rrd > int'(lat_D));
        iss = wr_D && reg_id_D != 0 && !stall && !mem_stall;
        if (iss) begin
            assert (lat_D >= 1 && int'(lat_D) <= MAX_LAT)
            else $error("illegal producer latency %0d on issue", lat_D);
        end
        last_flush = flush_DE;
        if (do_chk) begin
            chk("pc_enab",      pc_enab,      !(stall || mem_stall));
            chk("enab_FD",      enab_FD,      !(stall || mem_stall));
            chk("flush_DE",     flush_DE,     stall && !mem_stall);
            chk("enab_pipe",    enab_pipe,    !mem_stall);
            chk("forwardA_D",   forwardA_D,   fwd_e(int'(rs_D)) == 2);
            chk("forwardB_D",   forwardB_D,   fwd_e(int'(rt_D)) == 2);
            chk("forwardA_E",   forwardA_E,   fwd_e(int'(rs_E)));
            chk("forwardB_E",   forwardB_E,   fwd_e(int'(rt_E)));
            chk("stall_cycles", stall_cycles, perf_m);
        end
        if (ctrl_bus.reset) begin
            t_adv = 0;
            foreach (ready_at[r]) ready_at[r] = 0;
            perf_m = 0;
        end else begin
            if ((stall || mem_stall) && perf_m < PERF_MAX) perf_m++;
            if (!mem_stall) begin
                t_adv++;
                if (iss) ready_at[reg_id_D] = t_adv + longint'(lat_D);
            end
        end
        @(negedge ctrl_bus.clk);
    endtask

    task automatic do_reset();
        idle();
        ctrl_bus.reset = 1;
        step(0);
        ctrl_bus.reset = 0;
    endtask

    task automatic issue_wr(input int rd, input int lat);
        idle();
        wr_D = 1; reg_id_D = REG_BITS'(rd); lat_D = LAT_W'(lat);
        step(1);
    endtask

    int n;
    int perf_before;

    initial begin
        t_adv = 0; perf_m = 0;
        foreach (ready_at[r]) ready_at[r] = 0;
        idle();
        @(negedge ctrl_bus.clk);
        do_reset();

        chk("rst_pc_enab", pc_enab, 1);
        chk("rst_flush", flush_DE, 0);
        chk("rst_perf", stall_cycles, 0);

        // Load-use: one bubble, then forward from W.
        issue_wr(2, 2);
        idle(); use_rs_D = 1; use_rt_D = 1; rs_D = 5'd2; rt_D = 5'd2;
        wr_D = 1; reg_id_D = 5'd3; lat_D = 3'd1;
        step(1);
        chk("ld_use_flush", last_flush, 1);
        step(1);
        chk("ld_use_release", last_flush, 0);
        idle(); rs_E = 5'd2; reg_id_W = 5'd2; reg_write_W = 1;
        #1 chk("ld_use_fwdW", forwardA_E, 2'b01);
        step(1);

        // Branch after ALU producer (1 stall) and after load (2 stalls).
        for (int lat = 1; lat <= 2; lat++) begin
            issue_wr(5, lat);
            idle(); branch_D = 1; use_rs_D = 1; use_rt_D = 1; rs_D = 5'd5;
            n = 0;
            for (int k = 0; k < 10; k++) begin
                step(1);
                if (last_flush) n++; else break;
            end
            chk("branch_stalls", n, lat);
            reg_id_M = 5'd5; reg_write_M = 1;
            #1 chk("branch_fwdD", forwardA_D, 1);
            step(1);
        end

        // WAW: mul r7 lat4 followed by ALU write to r7.
        issue_wr(7, 4);
        idle(); wr_D = 1; reg_id_D = 5'd7; lat_D = 3'd1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (last_flush) n++; else break;
        end
        chk("waw_stalls", n, 3);
        idle(); step(1); step(1);

        // Freeze for 3 cycles while r2 has 2 cycles to go.
        issue_wr(2, 2);
        perf_before = perf_m;
        idle(); use_rs_D = 1; rs_D = 5'd2; mem_stall = 1;
        repeat (3) begin
            #1 chk("frz_flush", flush_DE, 0);
            chk("frz_enab_pipe", enab_pipe, 0);
            step(1);
        end
        mem_stall = 0;
        step(1);
        chk("frz_release_stall", last_flush, 1);
        step(1);
        chk("frz_resolved", last_flush, 0);
        chk("frz_perf_delta", stall_cycles, perf_before + 4);

        // r0 writes are never tracked or forwarded.
        issue_wr(0, 4);
        idle(); use_rs_D = 1; use_rt_D = 1; branch_D = 1;
        reg_write_M = 1; reg_write_W = 1;
        #1 chk("r0_no_stall", pc_enab, 1);
        chk("r0_no_fwdE", forwardA_E, 0);
        chk("r0_no_fwdD", forwardA_D, 0);
        step(1);

        // Reset with a pending entry.
        issue_wr(4, 3);
        idle(); use_rs_D = 1; rs_D = 5'd4; ctrl_bus.reset = 1;
        step(1);
        ctrl_bus.reset = 0;
        #1 chk("rst_mid_pc_enab", pc_enab, 1);
        chk("rst_mid_perf", stall_cycles, 0);
        step(1);

        // Randomised traffic with occasional freeze and reset.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rs_D = REG_BITS'($urandom_range(0, 7));
            rt_D = REG_BITS'($urandom_range(0, 7));
            use_rs_D = 1'($urandom);
            use_rt_D = 1'($urandom);
            branch_D = ($urandom_range(0, 4) == 0);
            wr_D = 1'($urandom);
            reg_id_D = REG_BITS'($urandom_range(0, 7));
            lat_D = LAT_W'($urandom_range(1, MAX_LAT));
            rs_E = REG_BITS'($urandom_range(0, 7));
            rt_E = REG_BITS'($urandom_range(0, 7));
            reg_id_M = REG_BITS'($urandom_range(0, 7));
            reg_id_W = REG_BITS'($urandom_range(0, 7));
            reg_write_M = 1'($urandom);
            reg_write_W = 1'($urandom);
            mem_stall = ($urandom_range(0, 5) == 0);
            ctrl_bus.reset = ($urandom_range(0, 299) == 0);
            step(1);
        end

        // Saturation of the stall counter.
        do_reset();
        idle(); mem_stall = 1;
        repeat ((1 << PERF_W) + 5) step(0);
        #1 chk("perf_saturate", stall_cycles, PERF_MAX);
        chk("perf_saturate_model", stall_cycles, perf_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
